// File: rtl/rgb_led_sequencer_pkg.sv
// Shared definitions for the RGB LED sequencer: FSM state encoding, palette and fade helper.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_FADE = 2'd0,
    ST_HOLD = 2'd1,
    ST_OVR  = 2'd2
  } seq_state_e;

  localparam logic [2:0] PALETTE_LAST = 3'd7;

  localparam logic [23:0] PALETTE [8] = '{
    24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF,
    24'h0000FF, 24'hFF00FF, 24'hFFFFFF, 24'h000000
  };

  // One linear fade step of a single 8-bit channel; never overshoots the target.
  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt)      return cur + 8'd1;
    else if (cur > tgt) return cur - 8'd1;
    else                return cur;
  endfunction

endpackage

// File: rtl/rgb_led_sequencer_if.sv
// Override request handshake: requester (master) presents a colour, sequencer (slave) accepts.
interface rgb_led_sequencer_if;
  logic        REQ_VALID;
  logic [23:0] REQ_RGB;
  logic        REQ_READY;

  modport master (output REQ_VALID, output REQ_RGB, input REQ_READY);
  modport slave  (input REQ_VALID, input REQ_RGB, output REQ_READY);
endinterface

// File: rtl/rgb_led_sequencer_pwm.sv
// One PWM output pin: lit while the shared counter is below the duty value, registered drive.
module rgb_pwm_channel #(
  parameter int unsigned PWM_BITS       = 8,
  parameter int unsigned LED_ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_en,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic [PWM_BITS-1:0] i_cnt,
  output logic                o_pin
);

  localparam logic UNLIT = (LED_ACTIVE_LOW != 0);

  logic w_lit;

  assign w_lit = (i_cnt < i_duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_pin <= UNLIT;
    end else if (i_en) begin
      o_pin <= w_lit ? ~UNLIT : UNLIT;
    end else begin
      o_pin <= UNLIT;
    end
  end

endmodule

// File: rtl/rgb_led_sequencer.sv
// Board RGB LED sequencer: palette fades and holds, one-shot colour override, PWM pin drive.
module rgb_led_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 12000,
  parameter int unsigned HOLD_TICKS     = 250,
  parameter int unsigned OVR_TICKS      = 500,
  parameter int unsigned PWM_BITS       = 8,
  parameter int unsigned LED_ACTIVE_LOW = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN,
  rgb_led_sequencer_if.slave   req,
  output logic [1:0]           STATE,
  output logic [2:0]           IDX,
  output logic                 LED_R,
  output logic                 LED_G,
  output logic                 LED_B
);

  localparam int unsigned PW   = $clog2(TICK_DIV);
  localparam int unsigned MAXT = (HOLD_TICKS > OVR_TICKS) ? HOLD_TICKS : OVR_TICKS;
  localparam int unsigned HW   = $clog2(MAXT) + 1;

  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] OVR_LAST  = HW'(OVR_TICKS - 1);

  logic [PW-1:0]       r_presc;
  logic [PWM_BITS-1:0] r_pwm;
  seq_state_e          r_state;
  logic [2:0]          r_idx;
  logic [23:0]         r_cur;
  logic [HW-1:0]       r_hold;
  logic                r_ready;

  logic        w_tick;
  logic        w_accept;
  logic [23:0] w_target;
  logic [23:0] w_faded;
  logic [2:0]  w_idx_next;

  assign w_tick     = EN & (r_presc == TICK_LAST);
  assign w_accept   = EN & r_ready & req.REQ_VALID;
  assign w_target   = PALETTE[r_idx];
  assign w_idx_next = (r_idx == PALETTE_LAST) ? '0 : r_idx + 3'd1;
  assign w_faded    = {step_toward(r_cur[23:16], w_target[23:16]),
                       step_toward(r_cur[15:8],  w_target[15:8]),
                       step_toward(r_cur[7:0],   w_target[7:0])};

  assign req.REQ_READY = EN & r_ready;
  assign STATE         = r_state;
  assign IDX           = r_idx;

  // Tick prescaler and shared PWM counter both freeze while disabled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc <= '0;
      r_pwm   <= '0;
    end else if (EN) begin
      r_presc <= (r_presc == TICK_LAST) ? '0 : r_presc + 1'b1;
      r_pwm   <= r_pwm + 1'b1;
    end
  end

  // Acceptance has priority: a tick landing on the same edge is dropped entirely.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_FADE;
      r_idx   <= '0;
      r_cur   <= '0;
      r_hold  <= '0;
      r_ready <= 1'b1;
    end else if (EN) begin
      if (w_accept) begin
        r_state <= ST_OVR;
        r_cur   <= req.REQ_RGB;
        r_hold  <= '0;
        r_ready <= 1'b0;
      end else if (w_tick) begin
        unique case (r_state)
          ST_FADE: begin
            if (r_cur == w_target) begin
              r_state <= ST_HOLD;
              r_hold  <= '0;
            end else begin
              r_cur <= w_faded;
            end
          end
          ST_HOLD: begin
            if (r_hold == HOLD_LAST) begin
              r_state <= ST_FADE;
              r_idx   <= w_idx_next;
              r_hold  <= '0;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
          ST_OVR: begin
            if (r_hold == OVR_LAST) begin
              r_state <= ST_FADE;
              r_hold  <= '0;
              r_ready <= 1'b1;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end
          default: begin
            r_state <= ST_FADE;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  rgb_pwm_channel #(
    .PWM_BITS       (PWM_BITS),
    .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
  ) u_pwm_r (
    .clk    (CLK),
    .rst_n  (RST_N),
    .i_en   (EN),
    .i_duty (r_cur[23 -: PWM_BITS]),
    .i_cnt  (r_pwm),
    .o_pin  (LED_R)
  );

  rgb_pwm_channel #(
    .PWM_BITS       (PWM_BITS),
    .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
  ) u_pwm_g (
    .clk    (CLK),
    .rst_n  (RST_N),
    .i_en   (EN),
    .i_duty (r_cur[15 -: PWM_BITS]),
    .i_cnt  (r_pwm),
    .o_pin  (LED_G)
  );

  rgb_pwm_channel #(
    .PWM_BITS       (PWM_BITS),
    .LED_ACTIVE_LOW (LED_ACTIVE_LOW)
  ) u_pwm_b (
    .clk    (CLK),
    .rst_n  (RST_N),
    .i_en   (EN),
    .i_duty (r_cur[7 -: PWM_BITS]),
    .i_cnt  (r_pwm),
    .o_pin  (LED_B)
  );

endmodule
